regfile_param: RTL and testbench

- Parametrised two-read/one-write register file for the datapath. It is the generalised successor of the fixed 32-bit, 64-entry file.
- Adds concurrent read and write in the same cycle, write-to-read bypass, a hardware clear sequence after reset, a ready indication, and range checking.
- Sits between the decode stage (which supplies the addresses) and the ALU/writeback path.

---
 rtl/regfile_param.sv | 53 +++++
 tb/tb_regfile_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: 2R/1W register file with a clear sweep after reset, write-first bypass and range checks; define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rs,
  output logic [DATA_WIDTH-1:0] rt,
  output logic                  ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_WIDTH:0]   DEP  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic rs_ok, rt_ok, wr_ok, run, wr_en;
`ifdef REGFILE_ZERO_REG_EN
  assign rs_ok = {1'b0, rs_addr} < DEP && rs_addr != '0;
  assign rt_ok = {1'b0, rt_addr} < DEP && rt_addr != '0;
  assign wr_ok = {1'b0, rd_addr} < DEP && rd_addr != '0;
`else
  assign rs_ok = {1'b0, rs_addr} < DEP;
  assign rt_ok = {1'b0, rt_addr} < DEP;
  assign wr_ok = {1'b0, rd_addr} < DEP;
`endif
  assign run   = state == RUN;
  assign ready = run;
  assign wr_en = run && write && wr_ok;
  always_comb state_nxt = (state == CLEAR && clr_ptr == LAST) ? RUN : state;
  always_ff @(posedge clock)
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      rs      <= '0;
      rt      <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= run ? clr_ptr : clr_ptr + ADDR_WIDTH'(1);
      rs      <= !run ? '0 : (wr_en && rd_addr == rs_addr) ? data_in : rs_ok ? mem[rs_addr] : '0;
      rt      <= !run ? '0 : (wr_en && rd_addr == rt_addr) ? data_in : rt_ok ? mem[rt_addr] : '0;
    end
  always_ff @(posedge clock)
    if (!reset && !run) mem[clr_ptr] <= '0;
    else if (!reset && wr_en) mem[rd_addr] <= data_in;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench driving a 64-entry and a 48-entry file with shared stimulus
module tb_regfile_param;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset, write;
  logic [5:0] rs_addr, rt_addr, rd_addr;
  logic [31:0] data_in, rs_a, rt_a, rs_b, rt_b;
  logic rdy_a, rdy_b;
  always #5 clock = ~clock;
  regfile_param dut_a (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .write(write), .data_in(data_in), .rs(rs_a), .rt(rt_a), .ready(rdy_a)
  );
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48)) dut_b (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .write(write), .data_in(data_in), .rs(rs_b), .rt(rt_b), .ready(rdy_b)
  );
  typedef struct packed {
    logic [31:0] rs_a;
    logic [31:0] rt_a;
    logic        rdy_a;
    logic [31:0] rs_b;
    logic [31:0] rt_b;
    logic        rdy_b;
  } obs_t;
  obs_t sb[$];
  obs_t e;
  logic [31:0] m [2][64];
  int cnt [2];
  bit run [2];
  int checks = 0;
  int failures = 0;
  function automatic obs_t got();
    return {rs_a, rt_a, rdy_a, rs_b, rt_b, rdy_b};
  endfunction
  task automatic model_edge(input int i, output logic [31:0] ers, output logic [31:0] ert, output logic erdy);
    int d;
    logic wok;
    d = i ? 48 : 64;
    ers = '0;
    ert = '0;
    if (reset) begin
      cnt[i] = 0;
      run[i] = 1'b0;
    end else if (!run[i]) begin
      m[i][cnt[i]] = '0;
      run[i] = cnt[i] == d - 1;
      cnt[i]++;
    end else begin
      wok = write && int'(rd_addr) < d && !(ZR && rd_addr == 6'd0);
      ers = (wok && rs_addr == rd_addr) ? data_in : (int'(rs_addr) < d && !(ZR && rs_addr == 6'd0)) ? m[i][rs_addr] : '0;
      ert = (wok && rt_addr == rd_addr) ? data_in : (int'(rt_addr) < d && !(ZR && rt_addr == 6'd0)) ? m[i][rt_addr] : '0;
      if (wok) m[i][rd_addr] = data_in;
    end
    erdy = run[i];
  endtask
  task automatic step(input logic rst, input logic w, input int rd, input int ra, input int rb, input logic [31:0] din);
    logic [31:0] a0, a1, b0, b1;
    logic ar, br;
    reset = rst;
    write = w;
    rd_addr = 6'(rd);
    rs_addr = 6'(ra);
    rt_addr = 6'(rb);
    data_in = din;
    model_edge(0, a0, a1, ar);
    model_edge(1, b0, b1, br);
    sb.push_back({a0, a1, ar, b0, b1, br});
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    int n, nb;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 5, 5, 5, 32'hFFFF_FFFF);
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got(), e); end
    end
    checks++;
    if (rdy_a !== 1'b0 || rs_a !== 32'd0 || rt_a !== 32'd0) begin
      failures++; $display("FAIL reset_values got rdy=%b rs=%h rt=%h exp 0/0/0", rdy_a, rs_a, rt_a);
    end
    n = 0;
    nb = 0;
    while (n < 100) begin
      step(0, 1, 9, 9, 9, 32'h1234);
      n++;
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL clear_seq cyc=%0d got=%h exp=%h", n, got(), e); end
      if (rdy_b && nb == 0) nb = n;
      if (rdy_a) break;
    end
    checks++;
    if (n != 64) begin failures++; $display("FAIL clear_len_64 got=%0d exp=64", n); end
    checks++;
    if (nb != 48) begin failures++; $display("FAIL clear_len_48 got=%0d exp=48", nb); end
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 0, i, 63 - i, 0);
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL cleared_read addr=%0d got=%h exp=%h", i, got(), e); end
      checks++;
      if (rs_a !== 32'd0 || rt_a !== 32'd0) begin failures++; $display("FAIL cleared_zero addr=%0d got=%h/%h exp=0", i, rs_a, rt_a); end
    end
  endtask
  task automatic test_write_read();
    step(0, 1, 5, 0, 0, 32'hDEAD_BEEF);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr5 got=%h exp=%h", got(), e); end
    step(0, 1, 63, 0, 0, 32'h1234_5678);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr63 got=%h exp=%h", got(), e); end
    step(0, 0, 0, 5, 63, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL rd5_63 got=%h exp=%h", got(), e); end
    checks++;
    if (rs_a !== 32'hDEAD_BEEF || rt_a !== 32'h1234_5678) begin
      failures++; $display("FAIL rd5_63_const got=%h/%h exp=deadbeef/12345678", rs_a, rt_a);
    end
  endtask
  task automatic test_bypass();
    step(0, 1, 7, 0, 0, 32'h1);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr7 got=%h exp=%h", got(), e); end
    step(0, 1, 7, 7, 7, 32'hA5A5_A5A5);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL bypass got=%h exp=%h", got(), e); end
    checks++;
    if (rs_a !== 32'hA5A5_A5A5 || rt_a !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL bypass_const got=%h/%h exp=a5a5a5a5", rs_a, rt_a);
    end
  endtask
  task automatic test_range();
    step(0, 1, 50, 50, 50, 32'hFFFF_FFFF);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr50 got=%h exp=%h", got(), e); end
    checks++;
    if (rs_b !== 32'd0 || rs_a !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL range_bypass got b=%h a=%h exp b=0 a=ffffffff", rs_b, rs_a);
    end
    step(0, 0, 0, 50, 50, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL rd50 got=%h exp=%h", got(), e); end
    checks++;
    if (rs_b !== 32'd0 || rt_b !== 32'd0) begin failures++; $display("FAIL rd50_zero got=%h/%h exp=0", rs_b, rt_b); end
    for (int i = 0; i < 48; i++) begin
      step(0, 0, 0, i, 47 - i, 0);
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL range_intact addr=%0d got=%h exp=%h", i, got(), e); end
    end
  endtask
  task automatic test_zero_reg();
    logic [31:0] exp0;
    exp0 = ZR ? 32'd0 : 32'h99;
    step(0, 1, 0, 0, 0, 32'h99);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr0 got=%h exp=%h", got(), e); end
    checks++;
    if (rs_a !== exp0) begin failures++; $display("FAIL wr0_bypass got=%h exp=%h", rs_a, exp0); end
    step(0, 0, 0, 0, 1, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL rd0 got=%h exp=%h", got(), e); end
    checks++;
    if (rs_a !== exp0) begin failures++; $display("FAIL rd0_const got=%h exp=%h", rs_a, exp0); end
  endtask
  task automatic test_back_to_back();
    int rd, ra, rb;
    for (int i = 0; i < 300; i++) begin
      rd = $urandom_range(0, 63);
      ra = $urandom_range(0, 2) == 0 ? rd : $urandom_range(0, 63);
      rb = $urandom_range(0, 2) == 0 ? rd : $urandom_range(0, 63);
      step(0, 1'($urandom_range(0, 1)), rd, ra, rb, $urandom);
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got(), e); end
    end
  endtask
  task automatic test_reset_mid();
    int n;
    step(1, 0, 0, 0, 0, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL mid_rst1 got=%h exp=%h", got(), e); end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0);
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL mid_clear cyc=%0d got=%h exp=%h", i, got(), e); end
    end
    step(1, 0, 0, 0, 0, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL mid_rst2 got=%h exp=%h", got(), e); end
    n = 0;
    while (n < 100) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL mid_resweep cyc=%0d got=%h exp=%h", n, got(), e); end
      if (rdy_a) break;
    end
    checks++;
    if (n != 64) begin failures++; $display("FAIL mid_clear_len got=%0d exp=64", n); end
    step(0, 1, 3, 0, 0, 32'h55);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL wr3 got=%h exp=%h", got(), e); end
    step(0, 0, 0, 3, 3, 0);
    e = sb.pop_front(); checks++;
    if (rs_a !== 32'h55 || got() !== e) begin failures++; $display("FAIL rd3 got=%h exp=%h", got(), e); end
    step(1, 0, 0, 0, 0, 0);
    e = sb.pop_front(); checks++;
    if (got() !== e) begin failures++; $display("FAIL run_rst got=%h exp=%h", got(), e); end
    n = 0;
    while (n < 100) begin
      step(0, 0, 0, 3, 3, 0);
      n++;
      e = sb.pop_front(); checks++;
      if (got() !== e) begin failures++; $display("FAIL run_resweep cyc=%0d got=%h exp=%h", n, got(), e); end
      if (rdy_a) break;
    end
    checks++;
    if (n != 64) begin failures++; $display("FAIL run_clear_len got=%0d exp=64", n); end
    step(0, 0, 0, 3, 3, 0);
    e = sb.pop_front(); checks++;
    if (rs_a !== 32'd0 || got() !== e) begin failures++; $display("FAIL rd3_cleared got=%h exp=%h", got(), e); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_range();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
